// File: rtl/dm_result_checker.sv
// Post-run data-memory checker: once the core reports done, walks a table of expected values and reports pass/fail.
// Define DMCHK_MISMATCH_MAP_EN to add the sticky per-entry mismatch_map output.
module dm_result_checker #(
  parameter int  DW         = 8,
  parameter int  AW         = 8,
  parameter int  NUM_CHECKS = 4,
  parameter int  TIMEOUT    = 1024,
  localparam int IW         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CW         = $clog2(NUM_CHECKS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dut_done,
  input  logic                  prog_we,
  input  logic [IW-1:0]         prog_idx,
  input  logic [AW-1:0]         prog_addr,
  input  logic [DW-1:0]         prog_exp,
  input  logic [DW-1:0]         prog_mask,
  output logic                  mem_rd,
  output logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [CW-1:0]         err_count,
`ifdef DMCHK_MISMATCH_MAP_EN
  output logic [NUM_CHECKS-1:0] mismatch_map,
`endif
  output logic [IW-1:0]         first_err_idx
);

  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CHECKS - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DONE = 3'd1,
    S_READ      = 3'd2,
    S_CMP       = 3'd3,
    S_FIN       = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic          fail_q, fail_d, timeout_q, timeout_d, mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0] err_count_q, err_count_d;
  logic [IW-1:0] first_err_idx_q, first_err_idx_d;
  logic [AW-1:0] tbl_addr_q [NUM_CHECKS];
  logic [AW-1:0] tbl_addr_d [NUM_CHECKS];
  logic [DW-1:0] tbl_exp_q  [NUM_CHECKS];
  logic [DW-1:0] tbl_exp_d  [NUM_CHECKS];
  logic [DW-1:0] tbl_mask_q [NUM_CHECKS];
  logic [DW-1:0] tbl_mask_d [NUM_CHECKS];
  logic          mismatch_s;
  logic [IW-1:0] idx_next_s;
`ifdef DMCHK_MISMATCH_MAP_EN
  logic [NUM_CHECKS-1:0] map_q, map_d;
`endif

  // Next-state, table-write and result computation.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    timer_d         = timer_q;
    busy_d          = busy_q;
    done_d          = done_q;
    pass_d          = pass_q;
    fail_d          = fail_q;
    timeout_d       = timeout_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    tbl_addr_d      = tbl_addr_q;
    tbl_exp_d       = tbl_exp_q;
    tbl_mask_d      = tbl_mask_q;
    mem_rd_d        = 1'b0;
    mem_addr_d      = {AW{1'b0}};
    idx_next_s      = idx_q + IW'(1'b1);
    mismatch_s      = ((mem_rdata ^ tbl_exp_q[idx_q]) & tbl_mask_q[idx_q]) != {DW{1'b0}};
`ifdef DMCHK_MISMATCH_MAP_EN
    map_d           = map_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A write in the start cycle lands before the first read of the run.
        if (prog_we && (int'(prog_idx) < NUM_CHECKS)) begin
          tbl_addr_d[prog_idx] = prog_addr;
          tbl_exp_d[prog_idx]  = prog_exp;
          tbl_mask_d[prog_idx] = prog_mask;
        end else begin
          tbl_addr_d = tbl_addr_q;
        end
        if (start) begin
          state_d         = S_WAIT_DONE;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          fail_d          = 1'b0;
          timeout_d       = 1'b0;
          err_count_d     = {CW{1'b0}};
          first_err_idx_d = {IW{1'b0}};
          timer_d         = {TW{1'b0}};
          idx_d           = {IW{1'b0}};
`ifdef DMCHK_MISMATCH_MAP_EN
          map_d           = {NUM_CHECKS{1'b0}};
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (dut_done) begin
          state_d    = S_READ;
          mem_rd_d   = 1'b1;
          mem_addr_d = tbl_addr_q[idx_q];
        end else if (timer_q == TIMER_LAST) begin
          state_d   = S_FIN;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          fail_d    = 1'b1;
          pass_d    = 1'b0;
          busy_d    = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end
      S_READ: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        if (mismatch_s) begin
          if (err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + CW'(1'b1);
          end else begin
            err_count_d = err_count_q;
          end
          if (err_count_q == {CW{1'b0}}) begin
            first_err_idx_d = idx_q;
          end else begin
            first_err_idx_d = first_err_idx_q;
          end
`ifdef DMCHK_MISMATCH_MAP_EN
          map_d[idx_q] = 1'b1;
`endif
        end else begin
          err_count_d = err_count_q;
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          fail_d  = (err_count_d != {CW{1'b0}});
          pass_d  = (err_count_d == {CW{1'b0}});
          busy_d  = 1'b0;
        end else begin
          state_d    = S_READ;
          idx_d      = idx_next_s;
          mem_rd_d   = 1'b1;
          mem_addr_d = tbl_addr_q[idx_next_s];
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, result and table registers; reset clears the table as well.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      idx_q           <= {IW{1'b0}};
      timer_q         <= {TW{1'b0}};
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      timeout_q       <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_addr_q      <= {AW{1'b0}};
      err_count_q     <= {CW{1'b0}};
      first_err_idx_q <= {IW{1'b0}};
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_addr_q[i] <= {AW{1'b0}};
        tbl_exp_q[i]  <= {DW{1'b0}};
        tbl_mask_q[i] <= {DW{1'b0}};
      end
`ifdef DMCHK_MISMATCH_MAP_EN
      map_q           <= {NUM_CHECKS{1'b0}};
`endif
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      timer_q         <= timer_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      timeout_q       <= timeout_d;
      mem_rd_q        <= mem_rd_d;
      mem_addr_q      <= mem_addr_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      tbl_addr_q      <= tbl_addr_d;
      tbl_exp_q       <= tbl_exp_d;
      tbl_mask_q      <= tbl_mask_d;
`ifdef DMCHK_MISMATCH_MAP_EN
      map_q           <= map_d;
`endif
    end
  end

  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
`ifdef DMCHK_MISMATCH_MAP_EN
  assign mismatch_map  = map_q;
`endif

endmodule

// File: tb/tb_dm_result_checker.sv
// Self-checking bench for dm_result_checker: directed vector table, hand-written corner sequences
// and randomized tables checked against a behavioural reference model.
module tb_dm_result_checker;
  localparam int N  = 4;
  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dut_done = 1'b0;
  logic       prog_we = 1'b0;
  logic [1:0] prog_idx = 2'd0;
  logic [7:0] prog_addr = 8'h00, prog_exp = 8'h00, prog_mask = 8'h00;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy, done, pass, fail, timeout;
  logic [2:0] err_count;
  logic [1:0] first_err_idx;
`ifdef DMCHK_MISMATCH_MAP_EN
  logic [3:0] mismatch_map;
`endif

  int         n_tests = 0;
  int         n_fail = 0;
  int         addr_viol = 0;
  logic [7:0] mem [256];
  logic [7:0] sh_addr [N];
  logic [7:0] sh_exp  [N];
  logic [7:0] sh_mask [N];
  logic [7:0] rd_log [$];
  logic [1:0] pend_idx;
  logic [7:0] pend_addr, pend_exp, pend_mask;

  typedef struct {
    string       name;
    logic [31:0] addrs;
    logic [31:0] exps;
    logic [31:0] masks;
    logic [31:0] mems;
    bit          exp_pass;
    int          exp_err;
    int          exp_first;
    logic [3:0]  exp_map;
  } vec_t;
  vec_t vecs [5];

  dm_result_checker #(.DW(8), .AW(8), .NUM_CHECKS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .dut_done(dut_done),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_addr(prog_addr),
    .prog_exp(prog_exp), .prog_mask(prog_mask),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_count(err_count),
`ifdef DMCHK_MISMATCH_MAP_EN
    .mismatch_map(mismatch_map),
`endif
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // Data memory: one-cycle read latency, garbage when not read; logs every read address.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_log.push_back(mem_addr);
    end else begin
      mem_rdata <= 8'hA5;
    end
  end

  always @(negedge clk) begin
    if (reset && !mem_rd && mem_addr != 8'h00) addr_viol++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic prog(input int i, input logic [7:0] a, input logic [7:0] e, input logic [7:0] m);
    @(negedge clk);
    prog_we = 1'b1; prog_idx = 2'(i); prog_addr = a; prog_exp = e; prog_mask = m;
    sh_addr[i] = a; sh_exp[i] = e; sh_mask[i] = m;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_vec(input int k);
    for (int i = 0; i < N; i++) begin
      mem[vecs[k].addrs[i*8 +: 8]] = vecs[k].mems[i*8 +: 8];
      prog(i, vecs[k].addrs[i*8 +: 8], vecs[k].exps[i*8 +: 8], vecs[k].masks[i*8 +: 8]);
    end
  endtask

  // Reference: an entry fails when any masked bit of memory differs from the expected value.
  function automatic void model(output int err, output int first, output logic [3:0] map);
    err = 0; first = 0; map = 4'b0000;
    for (int i = 0; i < N; i++) begin
      if (((mem[sh_addr[i]] ^ sh_exp[i]) & sh_mask[i]) != 8'h00) begin
        if (err == 0) first = i;
        err++;
        map[i] = 1'b1;
      end
    end
    if (err > 7) err = 7;
  endfunction

  // dly < 0: dut_done never rises (timeout run).
  task automatic run_check(input string nm, input int dly, input bit also_prog, input bit e_pass,
                           input int e_err, input int e_first, input logic [3:0] e_map);
    int base, cyc, nrd;
    base = rd_log.size();
    @(negedge clk);
    start = 1'b1;
    if (also_prog) begin
      prog_we = 1'b1; prog_idx = pend_idx; prog_addr = pend_addr; prog_exp = pend_exp; prog_mask = pend_mask;
      sh_addr[pend_idx] = pend_addr; sh_exp[pend_idx] = pend_exp; sh_mask[pend_idx] = pend_mask;
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_done_clr"}, done, 0);
    cyc = 0;
    if (dly >= 0) begin
      repeat (dly) @(negedge clk);
      dut_done = 1'b1;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (cyc == 2) dut_done = 1'b0;
      end
      chk({nm, "_latency"}, cyc, 2 * N + 1);
    end else begin
      while (!done && cyc < TO + 50) begin
        @(negedge clk);
        cyc++;
      end
      chk({nm, "_to_latency"}, cyc, TO);
    end
    dut_done = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_timeout"}, timeout, (dly < 0));
    chk({nm, "_pass"}, pass, e_pass);
    chk({nm, "_fail"}, fail, !e_pass);
    chk({nm, "_err"}, err_count, e_err);
    chk({nm, "_first"}, first_err_idx, e_first);
`ifdef DMCHK_MISMATCH_MAP_EN
    chk({nm, "_map"}, mismatch_map, e_map);
`else
    if (e_map === 4'bxxxx) $display("unexpected map");
`endif
    nrd = rd_log.size() - base;
    chk({nm, "_rd_pulses"}, nrd, (dly < 0) ? 0 : N);
    for (int i = 0; i < N && i < nrd; i++) chk({nm, "_rd_addr"}, rd_log[base + i], sh_addr[i]);
    repeat (3) @(negedge clk);
    chk({nm, "_sticky_done"}, done, 1);
    chk({nm, "_sticky_err"}, err_count, e_err);
  endtask

  initial begin
    int         cyc, base, m_err, m_first;
    logic [3:0] m_map;
    logic [7:0] a, e, m;

    vecs[0] = '{"pass",     32'h03020100, 32'h00000003, 32'h000000FF, 32'h11223303, 1'b1, 0, 0, 4'b0000};
    vecs[1] = '{"mismatch", 32'h04070506, 32'h55004100, 32'hFF00FF00, 32'h55884099, 1'b0, 1, 1, 4'b0010};
    vecs[2] = '{"mask",     32'h0A090803, 32'h000000C0, 32'h000000F0, 32'h000000C3, 1'b1, 0, 0, 4'b0000};
    vecs[3] = '{"all_bad",  32'h13121110, 32'h00000000, 32'hFFFFFFFF, 32'h04030201, 1'b0, 4, 0, 4'b1111};
    vecs[4] = '{"last_bad", 32'h23222120, 32'h5A007F80, 32'h0FFFFFFF, 32'hA5007F80, 1'b0, 1, 3, 4'b1000};
    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
    for (int i = 0; i < N; i++) begin
      sh_addr[i] = 8'h00; sh_exp[i] = 8'h00; sh_mask[i] = 8'h00;
    end

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_idx, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;

    for (int k = 0; k < 5; k++) begin
      load_vec(k);
      run_check(vecs[k].name, k * 3, 1'b0, vecs[k].exp_pass, vecs[k].exp_err,
                vecs[k].exp_first, vecs[k].exp_map);
    end

    // Busy guards: table write and a second start during the run are both ignored.
    load_vec(0);
    base = rd_log.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    prog_we = 1'b1; prog_idx = 2'd0; prog_addr = 8'h00; prog_exp = 8'h77; prog_mask = 8'hFF; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0; dut_done = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    dut_done = 1'b0;
    chk("guard_done", done, 1);
    chk("guard_pass", pass, 1);
    chk("guard_err", err_count, 0);
    repeat (10) @(negedge clk);
    chk("guard_idle", busy, 0);
    chk("guard_single_run", rd_log.size() - base, N);
    run_check("guard_table_kept", 1, 1'b0, 1'b1, 0, 0, 4'b0000);

    // Write and start in the same cycle: the run sees the new entry.
    pend_idx = 2'd0; pend_addr = 8'h00; pend_exp = 8'h04; pend_mask = 8'hFF;
    run_check("wr_with_start", 2, 1'b1, 1'b0, 1, 0, 4'b0001);

    run_check("timeout", -1, 1'b0, 1'b0, 0, 0, 4'b0000);

    // Asynchronous reset in the middle of the walk.
    load_vec(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; dut_done = 1'b1;
    cyc = 0;
    while (err_count == 3'd0 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("midrst_pre_err", err_count, 1);
    chk("midrst_pre_rd", mem_rd, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_mem_rd", mem_rd, 0);
    dut_done = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      sh_addr[i] = 8'h00; sh_exp[i] = 8'h00; sh_mask[i] = 8'h00;
    end
    run_check("rerun_cleared", 2, 1'b0, 1'b1, 0, 0, 4'b0000);

    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 32; j++) mem[j] = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        a = 8'($urandom_range(0, 31));
        case ($urandom_range(0, 2))
          32'd0:   m = 8'h00;
          32'd1:   m = 8'hFF;
          default: m = 8'($urandom);
        endcase
        e = ($urandom_range(0, 1) == 1) ? mem[a] : 8'($urandom);
        prog(i, a, e, m);
      end
      model(m_err, m_first, m_map);
      run_check("rand", int'($urandom_range(0, 12)), 1'b0, (m_err == 0), m_err, m_first, m_map);
    end

    chk("addr_zero_outside_read", addr_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
